// File: rtl/ssio_ddr_out_gear.sv
// Output gearbox for a source-synchronous DDR link: passes beats straight through at
// full rate, or stretches each beat over two divided output-clock periods at mid/low rate.
module ssio_ddr_out_gear #(
  parameter int               WIDTH      = 5,
  parameter int               DIV_MID    = 5,
  parameter int               DIV_LOW    = 50,
  parameter logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       speed,
  input  logic [WIDTH-1:0] input_d1,
  input  logic [WIDTH-1:0] input_d2,
  input  logic             input_valid,
  output logic             input_ready,
  output logic [WIDTH-1:0] output_d1,
  output logic [WIDTH-1:0] output_d2,
  output logic             output_clk_d1,
  output logic             output_clk_d2
);

  localparam int MAX_DIV = (DIV_MID > DIV_LOW) ? DIV_MID : DIV_LOW;
  localparam int CW      = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;
  localparam logic [CW-1:0] MID_LAST = CW'(DIV_MID - 1);
  localparam logic [CW-1:0] LOW_LAST = CW'(DIV_LOW - 1);

  typedef enum logic {PH_A, PH_B} phase_t;

  logic [1:0]       speed_reg, speed_n;
  logic [CW-1:0]    cnt, cnt_n, cnt_last;
  phase_t           phase, phase_n;
  logic [WIDTH-1:0] hold_d1, hold_d2, hold_d1_n, hold_d2_n;
  logic [WIDTH-1:0] out_d1_n, out_d2_n, slot_data;
  logic             clk_d1_n, clk_d2_n;
  logic             boundary, accept;
  logic [31:0]      div_n, slot;

  // speed 2 and 3 are both full rate, so bit 1 alone marks full mode.
  always_comb begin
    cnt_last = (speed_reg == 2'd1) ? MID_LAST : LOW_LAST;
    boundary = speed_reg[1] || ((cnt == cnt_last) && (phase == PH_B));
  end

  // Reset gating keeps a beat from being accepted and then lost to the reset.
  assign input_ready = boundary & ~rst;
  assign accept      = input_valid & input_ready;

  always_comb begin
    speed_n   = speed_reg;
    cnt_n     = cnt;
    phase_n   = phase;
    hold_d1_n = hold_d1;
    hold_d2_n = hold_d2;
    if (boundary) begin
      speed_n   = speed;
      cnt_n     = '0;
      phase_n   = PH_A;
      hold_d1_n = accept ? input_d1 : IDLE_VALUE;
      hold_d2_n = accept ? input_d2 : IDLE_VALUE;
    end else if (cnt == cnt_last) begin
      cnt_n   = '0;
      phase_n = PH_B;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end

  // Outputs are computed from next state so data and clock slot line up with cnt/phase.
  always_comb begin
    div_n     = (speed_n == 2'd1) ? 32'(DIV_MID) : 32'(DIV_LOW);
    slot      = 32'(cnt_n) << 1;
    slot_data = (phase_n == PH_A) ? hold_d1_n : hold_d2_n;
    out_d1_n  = slot_data;
    out_d2_n  = slot_data;
    clk_d1_n  = slot < div_n;
    clk_d2_n  = (slot + 32'd1) < div_n;
    if (speed_n[1]) begin
      out_d1_n = hold_d1_n;
      out_d2_n = hold_d2_n;
      clk_d1_n = 1'b1;
      clk_d2_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      speed_reg     <= 2'd2;
      cnt           <= '0;
      phase         <= PH_A;
      hold_d1       <= IDLE_VALUE;
      hold_d2       <= IDLE_VALUE;
      output_d1     <= IDLE_VALUE;
      output_d2     <= IDLE_VALUE;
      output_clk_d1 <= 1'b0;
      output_clk_d2 <= 1'b0;
    end else begin
      speed_reg     <= speed_n;
      cnt           <= cnt_n;
      phase         <= phase_n;
      hold_d1       <= hold_d1_n;
      hold_d2       <= hold_d2_n;
      output_d1     <= out_d1_n;
      output_d2     <= out_d2_n;
      output_clk_d1 <= clk_d1_n;
      output_clk_d2 <= clk_d2_n;
    end
  end

endmodule

// File: tb/tb_ssio_ddr_out_gear.sv
// Directed bench for ssio_ddr_out_gear: full, mid and low rate beats, idle beats,
// speed changes mid-beat and reset mid-beat, all with hand-written expected values.
module tb_ssio_ddr_out_gear;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] speed;
  logic [4:0] input_d1, input_d2;
  logic       input_valid, input_ready;
  logic [4:0] output_d1, output_d2;
  logic       output_clk_d1, output_clk_d2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ssio_ddr_out_gear #(
    .WIDTH(5), .DIV_MID(5), .DIV_LOW(50), .IDLE_VALUE(5'h00)
  ) dut (
    .clk(clk), .rst(rst), .speed(speed),
    .input_d1(input_d1), .input_d2(input_d2),
    .input_valid(input_valid), .input_ready(input_ready),
    .output_d1(output_d1), .output_d2(output_d2),
    .output_clk_d1(output_clk_d1), .output_clk_d2(output_clk_d2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Checks one divided beat cycle by cycle; non-boundary inputs are randomised to
  // show they are ignored, and the next beat is presented in the boundary cycle.
  task automatic run_div_beat(input int div, input logic [4:0] bd1, input logic [4:0] bd2,
                              input int ncyc, input logic [1:0] nspeed, input logic nvalid,
                              input logic [4:0] nd1, input logic [4:0] nd2);
    int cn;
    logic e1, e2;
    logic [9:0] mid_pat;
    mid_pat = 10'b11_11_10_00_00;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 2*div-1) begin
        speed = nspeed; input_valid = nvalid; input_d1 = nd1; input_d2 = nd2;
      end else begin
        speed       = 2'($urandom_range(0, 3));
        input_valid = 1'($urandom_range(0, 1));
        input_d1    = 5'($urandom_range(0, 31));
        input_d2    = 5'($urandom_range(0, 31));
      end
      #1;
      cn = c % div;
      if (div == 5) begin
        e1 = mid_pat[9-2*cn];
        e2 = mid_pat[8-2*cn];
      end else begin
        e1 = (cn < 25);
        e2 = e1;
      end
      check_eq("div_ready", input_ready, (c == 2*div-1));
      check_eq("div_d1", output_d1, (c < div) ? bd1 : bd2);
      check_eq("div_d2", output_d2, (c < div) ? bd1 : bd2);
      check_eq("div_clk_d1", output_clk_d1, e1);
      check_eq("div_clk_d2", output_clk_d2, e2);
    end
  endtask

  logic       fv  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [4:0] fd1 [4] = '{5'h1F, 5'h00, 5'h15, 5'h0A};
  logic [4:0] fd2 [4] = '{5'h00, 5'h1F, 5'h0A, 5'h15};

  initial begin
    rst = 1'b1; speed = 2'd2; input_valid = 1'b0; input_d1 = '0; input_d2 = '0;
    repeat (3) begin
      @(negedge clk); #1;
      check_eq("rst_ready", input_ready, 1'b0);
      check_eq("rst_d1", output_d1, 5'h00);
      check_eq("rst_d2", output_d2, 5'h00);
      check_eq("rst_clk_d1", output_clk_d1, 1'b0);
      check_eq("rst_clk_d2", output_clk_d2, 1'b0);
    end

    // First cycle after release is a boundary; full-rate beats follow.
    @(negedge clk);
    rst = 1'b0; speed = 2'd2;
    input_valid = fv[0]; input_d1 = fd1[0]; input_d2 = fd2[0];
    #1;
    check_eq("rel_ready", input_ready, 1'b1);
    check_eq("rel_d1", output_d1, 5'h00);
    check_eq("rel_clk_d1", output_clk_d1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        input_valid = fv[i+1]; input_d1 = fd1[i+1]; input_d2 = fd2[i+1];
      end else begin
        speed = 2'd1; input_valid = 1'b1; input_d1 = 5'h03; input_d2 = 5'h0A;
      end
      #1;
      check_eq("full_ready", input_ready, 1'b1);
      check_eq("full_d1", output_d1, fv[i] ? fd1[i] : 5'h00);
      check_eq("full_d2", output_d2, fv[i] ? fd2[i] : 5'h00);
      check_eq("full_clk_d1", output_clk_d1, 1'b1);
      check_eq("full_clk_d2", output_clk_d2, 1'b0);
    end

    // Mid rate; random speed inputs mid-beat must not change the rate.
    run_div_beat(5, 5'h03, 5'h0A, 10, 2'd1, 1'b1, 5'h1C, 5'h07);
    run_div_beat(5, 5'h1C, 5'h07, 10, 2'd2, 1'b1, 5'h1F, 5'h00);

    // Switched to full rate at the boundary: beat appears on the next cycle.
    @(negedge clk);
    speed = 2'd0; input_valid = 1'b1; input_d1 = 5'h15; input_d2 = 5'h0A;
    #1;
    check_eq("sw_ready", input_ready, 1'b1);
    check_eq("sw_d1", output_d1, 5'h1F);
    check_eq("sw_d2", output_d2, 5'h00);
    check_eq("sw_clk_d1", output_clk_d1, 1'b1);
    check_eq("sw_clk_d2", output_clk_d2, 1'b0);

    // Low rate, then an idle beat (valid low, data ignored), then back to mid.
    run_div_beat(50, 5'h15, 5'h0A, 100, 2'd0, 1'b0, 5'h1F, 5'h1F);
    run_div_beat(50, 5'h00, 5'h00, 100, 2'd1, 1'b1, 5'h06, 5'h19);

    // Reset arriving at phase B, cnt 2 abandons the beat.
    run_div_beat(5, 5'h06, 5'h19, 7, 2'd1, 1'b0, 5'h00, 5'h00);
    @(negedge clk);
    rst = 1'b1; input_valid = 1'b1;
    #1;
    check_eq("rstmid_ready", input_ready, 1'b0);
    check_eq("rstmid_d1", output_d1, 5'h19);
    check_eq("rstmid_clk_d1", output_clk_d1, 1'b1);
    check_eq("rstmid_clk_d2", output_clk_d2, 1'b0);
    @(negedge clk);
    rst = 1'b0; speed = 2'd1; input_valid = 1'b1; input_d1 = 5'h0C; input_d2 = 5'h13;
    #1;
    check_eq("rstrel_ready", input_ready, 1'b1);
    check_eq("rstrel_d1", output_d1, 5'h00);
    check_eq("rstrel_d2", output_d2, 5'h00);
    check_eq("rstrel_clk_d1", output_clk_d1, 1'b0);
    check_eq("rstrel_clk_d2", output_clk_d2, 1'b0);
    run_div_beat(5, 5'h0C, 5'h13, 10, 2'd2, 1'b0, 5'h00, 5'h00);

    // Idle full-rate beat: clock keeps running.
    @(negedge clk);
    speed = 2'd2; input_valid = 1'b0;
    #1;
    check_eq("end_ready", input_ready, 1'b1);
    check_eq("end_d1", output_d1, 5'h00);
    check_eq("end_d2", output_d2, 5'h00);
    check_eq("end_clk_d1", output_clk_d1, 1'b1);
    check_eq("end_clk_d2", output_clk_d2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ssio_ddr_out_gear.md
SSIO_DDR_OUT_GEAR -- requirements
Module: ssio_ddr_out_gear

Interface
REQ-001 SHALL have parameter WIDTH, default 5, lane count per DDR beat (e.g. 4 data + 1 ctl).
REQ-002 SHALL have parameter DIV_MID, default 5, clk cycles per output-clock period in mid-rate mode (min 2).
REQ-003 SHALL have parameter DIV_LOW, default 50, clk cycles per output-clock period in low-rate mode (min 2).
REQ-004 SHALL have parameter IDLE_VALUE, default {WIDTH{1'b0}}, lane value driven when no beat is supplied.
REQ-005 SHALL have ports: clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: speed  in  2  2 or 3 = full DDR, 1 = mid (DIV_MID), 0 = low (DIV_LOW).
REQ-008 SHALL have ports: input_d1, input_d2  in  WIDTH each  beat, first and second half.
REQ-009 SHALL have ports: input_valid  in  1; input_ready  out  1  beat handshake.
REQ-010 SHALL have ports: output_d1, output_d2  out  WIDTH each  rising/falling-edge data to the downstream ODDR.
REQ-011 SHALL have ports: output_clk_d1, output_clk_d2  out  1 each  rising/falling-edge pattern for the forwarded-clock ODDR.

Function
REQ-012 SHALL hold state speed_reg (2 bits), cnt (0..DIV-1, sized for max(DIV_MID,DIV_LOW)), phase (A/B).
REQ-013 Every output SHALL be registered; input_ready SHALL be decoded from registered state only.
REQ-014 Boundary SHALL be: speed_reg full, or (cnt == DIV-1 and phase == B), where DIV follows speed_reg.
REQ-015 input_ready SHALL be 1 exactly in boundary cycles; a beat is accepted when input_valid && input_ready.
REQ-016 At a boundary, speed_reg SHALL load speed, cnt SHALL load 0, phase SHALL load A; the new speed governs the beat accepted in that cycle.
REQ-017 Outside a boundary in divided modes, cnt SHALL increment; at cnt == DIV-1 it SHALL wrap to 0 and phase SHALL toggle A->B.
REQ-018 Full mode: next cycle output_d1/output_d2 SHALL equal input_d1/input_d2 if accepted, else IDLE_VALUE on both; output_clk_d1/d2 = 1/0; latency 1 cycle.
REQ-019 Divided mode, phase A: output_d1 = output_d2 = beat d1 (or IDLE_VALUE if no beat accepted) for all DIV cycles.
REQ-020 Divided mode, phase B: output_d1 = output_d2 = beat d2 (or IDLE_VALUE) for all DIV cycles; the beat is held internally across both phases.
REQ-021 Divided clock: half-slot k = 2*cnt (d1) and 2*cnt+1 (d2); output_clk bit SHALL be 1 iff k < DIV; odd DIV gives the 1/0 slot at cnt == (DIV-1)/2.
REQ-022 Output data and clock pattern for a given cnt/phase SHALL appear in the same cycle; the first phase-A cycle carries the rising clock edge.
REQ-023 A speed change SHALL take effect only at a boundary; the in-flight beat completes both phases at the old rate.
REQ-024 input_valid low at a boundary SHALL produce an idle beat (both phases IDLE_VALUE) with the clock still toggling; the clock never stops outside reset.
REQ-025 input_d1/input_d2 SHALL be ignored in non-boundary cycles.

Reset
REQ-026 rst high SHALL set speed_reg = full, cnt = 0, phase = A, held beat = IDLE_VALUE, output_d1/d2 = IDLE_VALUE, output_clk_d1/d2 = 0/0, input_ready = 0.
REQ-027 rst high mid-beat SHALL abandon the beat with no further output of it; the first cycle after rst deasserts SHALL be a boundary (input_ready = 1).

Verification
REQ-028 Full mode, speed=2, valid beats 0x1F/0x00 each cycle -> output_d1 = 0x1F, output_d2 = 0x00 one cycle later; clk pattern 1/0 every cycle; ready constant 1.
REQ-029 Mid mode, DIV_MID=5, beat d1=0x3, d2=0xA -> 5 cycles 0x3 on both edges, then 5 cycles 0xA; clk slots per cycle 11,11,10,00,00 in both phases; ready once per 10 cycles.
REQ-030 Low mode, DIV_LOW=50 -> clk high for cnt 0..24, low for 25..49, 100 cycles per beat; input_valid low at the boundary -> IDLE_VALUE for 100 cycles, clock continues.
REQ-031 speed 1->2 toggled mid-phase-A -> current beat finishes phase B at mid rate; the next boundary switches to full rate, and the first full-rate beat appears the following cycle.
REQ-032 rst pulsed at cnt=2 of phase B -> next cycle outputs IDLE_VALUE, clk 0/0; after release, ready = 1 in the first cycle, and a new beat starts with phase A, cnt = 0.
